// File: rtl/dl_region_ctrl.sv
// HPS download decoder: routes ROM bytes into CPU/sound/wave regions, captures mod/DIP bytes, sequences core reset.
// Optional running checksum of mapped ROM bytes when DL_REGION_CHECKSUM_EN is defined.
module dl_region_ctrl #(
   parameter int HOLD_CYCLES = 16
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   input  logic [7:0]  ioctl_index,
   output logic        cpu_we,
   output logic        snd_we,
   output logic        wav_we,
   output logic [15:0] wr_addr,
   output logic [7:0]  wr_data,
   output logic [7:0]  mod,
   output logic [7:0]  dip_sw,
   output logic        core_reset,
   output logic        rom_loaded,
`ifdef DL_REGION_CHECKSUM_EN
   output logic [7:0]  csum,
`endif
   output logic        unmapped
);

   localparam int CNT_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {WAIT_ROM, LOADING, HOLD, RUN} state_t;

   state_t         state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic           dl_prev_q, dl_prev_d;
   logic           armed_q, armed_d;
   logic           cpu_we_q, cpu_we_d;
   logic           snd_we_q, snd_we_d;
   logic           wav_we_q, wav_we_d;
   logic [15:0]    wr_addr_q, wr_addr_d;
   logic [7:0]     wr_data_q, wr_data_d;
   logic [7:0]     mod_q, mod_d;
   logic [7:0]     dip_sw_q, dip_sw_d;
   logic           core_reset_q, core_reset_d;
   logic           rom_loaded_q, rom_loaded_d;
   logic           unmapped_q, unmapped_d;
`ifdef DL_REGION_CHECKSUM_EN
   logic [7:0]     csum_q, csum_d;
`endif

   logic dl_active, wr_act, rom_wr, hit_cpu, hit_snd, hit_wav, hit_any;

   always_comb begin
      // A download is only honoured once its rising edge has been seen since reset.
      dl_active = ioctl_download & (armed_q | ~dl_prev_q);
      wr_act    = dl_active & ioctl_wr;
      rom_wr    = wr_act & (ioctl_index == 8'd0);
      hit_cpu   = rom_wr & (ioctl_addr[24:15] == 10'd0);
      hit_snd   = rom_wr & (ioctl_addr[24:12] == 13'h00E);
      hit_wav   = rom_wr & (ioctl_addr[24:16] == 9'h001);
      hit_any   = hit_cpu | hit_snd | hit_wav;

      dl_prev_d = ioctl_download;
      armed_d   = dl_active;

      cpu_we_d  = hit_cpu;
      snd_we_d  = hit_snd;
      wav_we_d  = hit_wav;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      if (hit_cpu) begin
         wr_addr_d = {1'b0, ioctl_addr[14:0]};
      end else if (hit_snd) begin
         wr_addr_d = {4'd0, ioctl_addr[11:0]};
      end else if (hit_wav) begin
         wr_addr_d = ioctl_addr[15:0];
      end
      if (hit_any) begin
         wr_data_d = ioctl_dout;
      end

      unmapped_d = unmapped_q | (rom_wr & ~hit_any);
      mod_d      = (wr_act && ioctl_index == 8'd1) ? ioctl_dout : mod_q;
      dip_sw_d   = (wr_act && ioctl_index == 8'd254 && ioctl_addr == 25'd0) ? ioctl_dout : dip_sw_q;

      state_d      = state_q;
      cnt_d        = cnt_q;
      rom_loaded_d = rom_loaded_q;
      if (dl_active && ioctl_index == 8'd0) begin
         state_d = LOADING;
      end else begin
         case (state_q)
            LOADING: begin
               if (!ioctl_download) begin
                  state_d = HOLD;
                  cnt_d   = CNT_LOAD;
               end
            end
            HOLD: begin
               if (cnt_q == '0) begin
                  state_d      = RUN;
                  rom_loaded_d = 1'b1;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            default: ;
         endcase
      end
      core_reset_d = (state_q != RUN);

`ifdef DL_REGION_CHECKSUM_EN
      // Entering LOADING restarts the sum, including any byte written on that same cycle.
      csum_d = ((state_d == LOADING) && (state_q != LOADING)) ? 8'd0 : csum_q;
      if (hit_any) begin
         csum_d = csum_d + ioctl_dout;
      end
`endif
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q      <= WAIT_ROM;
         cnt_q        <= '0;
         dl_prev_q    <= 1'b1;
         armed_q      <= 1'b0;
         cpu_we_q     <= 1'b0;
         snd_we_q     <= 1'b0;
         wav_we_q     <= 1'b0;
         wr_addr_q    <= 16'd0;
         wr_data_q    <= 8'd0;
         mod_q        <= 8'd0;
         dip_sw_q     <= 8'd0;
         core_reset_q <= 1'b1;
         rom_loaded_q <= 1'b0;
         unmapped_q   <= 1'b0;
`ifdef DL_REGION_CHECKSUM_EN
         csum_q       <= 8'd0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         dl_prev_q    <= dl_prev_d;
         armed_q      <= armed_d;
         cpu_we_q     <= cpu_we_d;
         snd_we_q     <= snd_we_d;
         wav_we_q     <= wav_we_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         mod_q        <= mod_d;
         dip_sw_q     <= dip_sw_d;
         core_reset_q <= core_reset_d;
         rom_loaded_q <= rom_loaded_d;
         unmapped_q   <= unmapped_d;
`ifdef DL_REGION_CHECKSUM_EN
         csum_q       <= csum_d;
`endif
      end
   end

   assign cpu_we     = cpu_we_q;
   assign snd_we     = snd_we_q;
   assign wav_we     = wav_we_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign mod        = mod_q;
   assign dip_sw     = dip_sw_q;
   assign core_reset = core_reset_q;
   assign rom_loaded = rom_loaded_q;
   assign unmapped   = unmapped_q;
`ifdef DL_REGION_CHECKSUM_EN
   assign csum       = csum_q;
`endif

endmodule

// File: tb/tb_dl_region_ctrl.sv
// Directed + randomized bench for dl_region_ctrl against an address-range reference model.
module tb_dl_region_ctrl;
   localparam int HOLD = 16;

   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic        ioctl_download = 1'b0;
   logic        ioctl_wr = 1'b0;
   logic [24:0] ioctl_addr = '0;
   logic [7:0]  ioctl_dout = '0;
   logic [7:0]  ioctl_index = '0;
   logic        cpu_we, snd_we, wav_we, core_reset, rom_loaded, unmapped;
   logic [15:0] wr_addr;
   logic [7:0]  wr_data, mod, dip_sw;
`ifdef DL_REGION_CHECKSUM_EN
   logic [7:0]  csum;
`endif

   dl_region_ctrl #(.HOLD_CYCLES(HOLD)) dut (
      .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
      .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
      .cpu_we(cpu_we), .snd_we(snd_we), .wav_we(wav_we), .wr_addr(wr_addr), .wr_data(wr_data),
      .mod(mod), .dip_sw(dip_sw), .core_reset(core_reset), .rom_loaded(rom_loaded),
`ifdef DL_REGION_CHECKSUM_EN
      .csum(csum),
`endif
      .unmapped(unmapped)
   );

   always #5 clk_sys = ~clk_sys;

   int checks = 0;
   int failures = 0;
   logic       exp_unmapped = 1'b0;
   logic [7:0] exp_mod = 8'd0;
   logic [7:0] exp_dip = 8'd0;
   logic [7:0] exp_csum = 8'd0;

   task automatic check1(input string tag, input logic obs, input logic expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
      end
   endtask

   task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic tick;
      @(posedge clk_sys);
      #1;
   endtask

   // Region map: 1 = CPU, 2 = sound, 3 = wave, 0 = unmapped; offset is relative to the region base.
   function automatic void ref_decode(input int unsigned a, output int region, output int unsigned off);
      region = 0;
      off    = 0;
      if (a < 32'h8000) begin
         region = 1; off = a;
      end else if (a >= 32'hE000 && a < 32'hF000) begin
         region = 2; off = a - 32'hE000;
      end else if (a >= 32'h10000 && a < 32'h20000) begin
         region = 3; off = a - 32'h10000;
      end
   endfunction

   function automatic logic [24:0] gen_addr(input bit allow_unmapped);
      int sel;
      sel = allow_unmapped ? int'($urandom_range(0, 3)) : int'($urandom_range(1, 3));
      case (sel)
         1: return 25'($urandom_range(0, 32'h7FFF));
         2: return 25'(32'hE000 + $urandom_range(0, 32'hFFF));
         3: return 25'(32'h10000 + $urandom_range(0, 32'hFFFF));
         default: begin
            case ($urandom_range(0, 2))
               0: return 25'(32'h8000 + $urandom_range(0, 32'h5FFF));
               1: return 25'(32'hF000 + $urandom_range(0, 32'hFFF));
               default: return 25'(32'h20000 + $urandom_range(0, 32'h1FDFFFF));
            endcase
         end
      endcase
   endfunction

   task automatic rom_byte(input logic [24:0] a, input logic [7:0] d);
      int region;
      int unsigned off;
      ref_decode({7'd0, a}, region, off);
      if (region == 0) exp_unmapped = 1'b1;
      else exp_csum = exp_csum + d;
      ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
      tick;
      ioctl_wr = 1'b0;
      check1("cpu_we", cpu_we, region == 1);
      check1("snd_we", snd_we, region == 2);
      check1("wav_we", wav_we, region == 3);
      if (region != 0) begin
         check16("wr_addr", wr_addr, 16'(off));
         check8("wr_data", wr_data, d);
      end
      check1("unmapped", unmapped, exp_unmapped);
      tick;
      check1("strobe_one_cycle", cpu_we | snd_we | wav_we, 1'b0);
   endtask

   task automatic other_byte(input logic [24:0] a, input logic [7:0] d);
      if (ioctl_index == 8'd1) exp_mod = d;
      if (ioctl_index == 8'd254 && a == 25'd0) exp_dip = d;
      ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
      tick;
      ioctl_wr = 1'b0;
      check1("no_rom_strobe", cpu_we | snd_we | wav_we, 1'b0);
      check8("mod", mod, exp_mod);
      check8("dip_sw", dip_sw, exp_dip);
   endtask

   task automatic start_rom;
      ioctl_index = 8'd0; ioctl_download = 1'b1; exp_csum = 8'd0;
      tick;
   endtask

   // Caller has just clocked the edge on which ioctl_download was seen low.
   task automatic hold_check(input string tag);
      for (int k = 1; k <= HOLD; k++) begin
         tick;
         check1({tag, "_hold_core_reset"}, core_reset, 1'b1);
      end
      check1({tag, "_rom_loaded"}, rom_loaded, 1'b1);
      tick;
      check1({tag, "_run_core_reset"}, core_reset, 1'b0);
   endtask

   initial begin
      // Reset state
      tick; tick;
      check1("rst_cpu_we", cpu_we, 1'b0);
      check1("rst_snd_we", snd_we, 1'b0);
      check1("rst_wav_we", wav_we, 1'b0);
      check16("rst_wr_addr", wr_addr, 16'd0);
      check8("rst_wr_data", wr_data, 8'd0);
      check8("rst_mod", mod, 8'd0);
      check8("rst_dip", dip_sw, 8'd0);
      check1("rst_core_reset", core_reset, 1'b1);
      check1("rst_rom_loaded", rom_loaded, 1'b0);
      check1("rst_unmapped", unmapped, 1'b0);
      reset = 1'b0;
      tick;

      // First ROM download: directed corners, then random mapped bytes, then unmapped ones
      start_rom;
      rom_byte(25'h0000000, 8'hAA);
      rom_byte(25'h0007FFF, 8'h55);
      rom_byte(25'h000E123, 8'h12);
      rom_byte(25'h001FFFF, 8'h34);
      for (int i = 0; i < 20; i++) rom_byte(gen_addr(1'b0), 8'($urandom));
      check1("unmapped_still_clear", unmapped, 1'b0);
      rom_byte(25'h0009000, 8'h66);
      for (int i = 0; i < 20; i++) rom_byte(gen_addr(1'b1), 8'($urandom));

      // Download ends with a stray write strobe that must be ignored
      ioctl_download = 1'b0; ioctl_wr = 1'b1; ioctl_addr = 25'd0;
      tick;
      ioctl_wr = 1'b0;
      check1("no_strobe_when_idle", cpu_we | snd_we | wav_we, 1'b0);
      check1("rom_loaded_before_hold", rom_loaded, 1'b0);
`ifdef DL_REGION_CHECKSUM_EN
      check8("csum_first_load", csum, exp_csum);
`endif
      hold_check("first");

      // Restart during HOLD: second download, abort 5 cycles into HOLD, then checksum bytes
      start_rom;
      rom_byte(gen_addr(1'b0), 8'($urandom));
      ioctl_download = 1'b0;
      tick;
      for (int k = 0; k < 5; k++) begin
         tick;
         check1("hold_before_restart", core_reset, 1'b1);
      end
      start_rom;
      check1("restart_core_reset", core_reset, 1'b1);
      rom_byte(25'h0000010, 8'h80);
      rom_byte(25'h000E000, 8'h90);
      rom_byte(25'h0010000, 8'h10);
      check1("restart_loading_core_reset", core_reset, 1'b1);
      ioctl_download = 1'b0;
      tick;
`ifdef DL_REGION_CHECKSUM_EN
      check8("csum_0x20", csum, 8'h20);
`endif
      hold_check("restart");

      // DIP and mod captures while running
      ioctl_index = 8'd254; ioctl_download = 1'b1;
      tick;
      other_byte(25'd0, 8'h3C);
      other_byte(25'd1, 8'hFF);
      for (int i = 0; i < 4; i++) other_byte(25'($urandom_range(1, 32'h1FFFFFF)), 8'($urandom));
      ioctl_download = 1'b0;
      tick;
      ioctl_index = 8'd1; ioctl_download = 1'b1;
      tick;
      for (int i = 0; i < 4; i++) other_byte(25'($urandom), 8'($urandom));
      other_byte(25'($urandom), 8'h02);
      ioctl_download = 1'b0;
      tick; tick; tick;
      check8("dip_final", dip_sw, 8'h3C);
      check8("mod_final", mod, 8'h02);
      check1("run_kept_core_reset", core_reset, 1'b0);
      check1("run_kept_rom_loaded", rom_loaded, 1'b1);

      // Reset in the middle of a ROM download drops the byte and the rest of that download
      start_rom;
      rom_byte(25'h0000100, 8'h11);
      ioctl_wr = 1'b1; ioctl_addr = 25'h0000200; ioctl_dout = 8'h77; reset = 1'b1;
      tick;
      reset = 1'b0; ioctl_addr = 25'h0000300;
      tick;
      ioctl_wr = 1'b0;
      exp_unmapped = 1'b0; exp_mod = 8'd0; exp_dip = 8'd0;
      check1("midrst_cpu_we", cpu_we, 1'b0);
      check16("midrst_wr_addr", wr_addr, 16'd0);
      check1("midrst_core_reset", core_reset, 1'b1);
      check1("midrst_rom_loaded", rom_loaded, 1'b0);
      check8("midrst_mod", mod, 8'd0);
      check8("midrst_dip", dip_sw, 8'd0);
      ioctl_wr = 1'b1; ioctl_addr = 25'h0009000;
      tick;
      ioctl_wr = 1'b0;
      tick;
      check1("midrst_ignored_unmapped", unmapped, 1'b0);
      ioctl_download = 1'b0;
      tick;
      tick;
      check1("midrst_no_hold", core_reset, 1'b1);
      check1("midrst_not_loaded", rom_loaded, 1'b0);
      start_rom;
      rom_byte(25'h0000042, 8'h99);
      rom_byte(gen_addr(1'b0), 8'($urandom));
      ioctl_download = 1'b0;
      tick;
`ifdef DL_REGION_CHECKSUM_EN
      check8("csum_after_midrst", csum, exp_csum);
`endif
      hold_check("after_midrst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/dl_region_ctrl.md
DL_REGION_CTRL -- requirements
Module: dl_region_ctrl

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 16: clk_sys cycles that core_reset stays asserted after a ROM download ends.
REQ-002 SHALL have port clk_sys  in  1  system clock; the only clock.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port ioctl_download  in  1  HPS download in progress.
REQ-005 SHALL have port ioctl_wr  in  1  one-cycle byte-write strobe.
REQ-006 SHALL have port ioctl_addr  in  25  byte address.
REQ-007 SHALL have port ioctl_dout  in  8  byte data.
REQ-008 SHALL have port ioctl_index  in  8  download index: 0 ROM, 1 mod, 254 DIP.
REQ-009 SHALL have port cpu_we / snd_we / wav_we  out  1 each  region write strobes.
REQ-010 SHALL have port wr_addr  out  16  region-relative address.
REQ-011 SHALL have port wr_data  out  8  write data.
REQ-012 SHALL have port mod  out  8  captured game-variant byte.
REQ-013 SHALL have port dip_sw  out  8  captured DIP byte 0.
REQ-014 SHALL have port core_reset  out  1  core hold-in-reset.
REQ-015 SHALL have port rom_loaded  out  1  at least one ROM download has completed.
REQ-016 SHALL have port unmapped  out  1  sticky flag: a ROM byte fell outside all regions.

Function
REQ-017 SHALL decode ROM writes (index 0, ioctl_download=1, ioctl_wr=1) as follows: addr < 0x8000 -> cpu_we with wr_addr = addr[14:0]; 0xE000 <= addr < 0xF000 -> snd_we with wr_addr = addr[11:0]; 0x10000 <= addr < 0x20000 -> wav_we with wr_addr = addr[15:0]; any other address sets unmapped.
REQ-018 SHALL register the strobes, wr_addr and wr_data with exactly 1 cycle of latency from ioctl_wr; the strobes are one-hot or all zero, and each is high for exactly one cycle per byte.
REQ-019 SHALL drive no strobe when ioctl_wr=1 while ioctl_download=0.
REQ-020 SHALL capture mod on an index 1 write at any address; the last write wins.
REQ-021 SHALL capture dip_sw on an index 254 write only when addr == 0; other addresses are ignored.
REQ-022 SHALL have FSM states WAIT_ROM, LOADING, HOLD and RUN.
REQ-023 SHALL leave reset in WAIT_ROM.
REQ-024 SHALL enter LOADING from any state when ioctl_download=1 and index=0.
REQ-025 SHALL move from LOADING to HOLD on the cycle ioctl_download=0, loading the counter with HOLD_CYCLES-1.
REQ-026 SHALL, in HOLD, decrement the counter each cycle and enter RUN when the counter is 0; rom_loaded is set on that same transition.
REQ-027 SHALL, if a new ROM download starts during HOLD, return to LOADING and discard the counter.
REQ-028 SHALL not change FSM state for downloads with index != 0.
REQ-029 SHALL drive core_reset = 1 in every state except RUN; it is registered from the FSM state.

Reset
REQ-030 SHALL drive all outputs to 0 on reset, except core_reset = 1; mod, dip_sw, unmapped and rom_loaded clear; FSM to WAIT_ROM.
REQ-031 SHALL, if reset occurs mid-download, drop the in-flight byte and ignore further writes until the next rising edge of ioctl_download.

Configuration
REQ-032 SHALL, with DL_REGION_CHECKSUM_EN defined, add output csum [7:0]: the modulo-256 sum of every mapped ROM byte written; it clears on entry to LOADING and is valid from HOLD onward.
REQ-033 SHALL, without DL_REGION_CHECKSUM_EN, have no csum port and no adder logic.

Verification
REQ-034 SHALL cover: reset, index 0 download of bytes 0xAA @0x0000 and 0x55 @0x7FFF -> cpu_we pulses 1 cycle later with wr_addr 0x0000 and 0x7FFF; snd_we and wav_we stay 0.
REQ-035 SHALL cover: bytes @0xE123 and @0x1FFFF -> snd_we with wr_addr 0x123, wav_we with wr_addr 0xFFFF; byte @0x9000 -> no strobe and unmapped = 1.
REQ-036 SHALL cover: ioctl_download falls at cycle T -> core_reset stays 1 through T+HOLD_CYCLES, then goes 0 and rom_loaded = 1 (HOLD_CYCLES = 16).
REQ-037 SHALL cover: a new index 0 download starts 5 cycles into HOLD -> core_reset remains 1 and the FSM returns to LOADING, then completes a full HOLD_CYCLES hold after the second download ends.
REQ-038 SHALL cover: index 254 writes 0x3C @0 and 0xFF @1, then an index 1 write of 0x02 -> dip_sw = 0x3C, mod = 0x02; FSM stays in RUN.
REQ-039 SHALL cover, with DL_REGION_CHECKSUM_EN: mapped bytes 0x80, 0x90, 0x10 -> csum = 0x20.
